// File: rtl/input_cond_pkg.sv
// Shared constants and helpers for the input conditioner.
// Optional INPUT_COND_FALL_EN adds a falling-edge pulse output.
package input_cond_pkg;

   localparam int INPUT_COND_SYNC_STAGES_DEF = 2;
   localparam int INPUT_COND_DEBOUNCE_DEF    = 1000000;

   function automatic int cnt_width(int cycles);
      int w;
      w = $clog2(cycles);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/input_cond_ch.sv
// One conditioner channel: synchroniser, debounce counter, edge pulses.
// Optional INPUT_COND_FALL_EN adds fall_o.
module input_cond_ch
   import input_cond_pkg::*;
#(
   parameter int SYNC_STAGES     = INPUT_COND_SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = INPUT_COND_DEBOUNCE_DEF
) (
   input  logic clk_i,
   input  logic arst_i,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o
`ifdef INPUT_COND_FALL_EN
   ,
   output logic fall_o
`endif
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   stable_q, stable_d;
   logic                   rise_q, rise_d;
   logic                   fall_d;
   logic                   sync;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
   assign sync   = sync_q[SYNC_STAGES-1];

   // Any match clears the count, so a glitch never accumulates.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      if (sync != stable_q) begin
         if (cnt_q == CNT_MAX) begin
            stable_d = sync;
            rise_d   = sync;
            fall_d   = ~sync;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
         rise_q   <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         rise_q   <= rise_d;
      end
   end

   assign level_o = stable_q;
   assign rise_o  = rise_q;

`ifdef INPUT_COND_FALL_EN
   logic fall_q;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         fall_q <= 1'b0;
      end else begin
         fall_q <= fall_d;
      end
   end

   assign fall_o = fall_q;
`else
   logic unused_fall;
   assign unused_fall = fall_d;
`endif

endmodule

// File: rtl/input_cond.sv
// Multi-channel push-button / switch conditioner feeding the SoC.
// Optional INPUT_COND_FALL_EN adds fall_o.
module input_cond
   import input_cond_pkg::*;
#(
   parameter int NCH             = 17,
   parameter int SYNC_STAGES     = INPUT_COND_SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = INPUT_COND_DEBOUNCE_DEF
) (
   input  logic           clk_i,
   input  logic           arst_i,
   input  logic [NCH-1:0] raw_i,
   output logic [NCH-1:0] level_o,
   output logic [NCH-1:0] rise_o
`ifdef INPUT_COND_FALL_EN
   ,
   output logic [NCH-1:0] fall_o
`endif
);

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      input_cond_ch #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
         .clk_i  (clk_i),
         .arst_i (arst_i),
         .raw_i  (raw_i[g]),
         .level_o(level_o[g]),
         .rise_o (rise_o[g])
`ifdef INPUT_COND_FALL_EN
         ,
         .fall_o (fall_o[g])
`endif
      );
   end

endmodule

// File: tb/tb_input_cond.sv
// Bench for input_cond: directed scenarios plus random raw traffic
// checked against a sliding-window model of the debounce rule.
module tb_input_cond;

   localparam int S = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] raw = 2'b00;

   logic [1:0] lv4, rs4, lv1, rs1;
`ifdef INPUT_COND_FALL_EN
   logic [1:0] fl4, fl1;
`endif

   always #5 clk = ~clk;

   input_cond #(.NCH(2), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(4)) u4 (
      .clk_i  (clk),
      .arst_i (rst),
      .raw_i  (raw),
      .level_o(lv4),
      .rise_o (rs4)
`ifdef INPUT_COND_FALL_EN
      ,
      .fall_o (fl4)
`endif
   );

   input_cond #(.NCH(2), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(1)) u1 (
      .clk_i  (clk),
      .arst_i (rst),
      .raw_i  (raw),
      .level_o(lv1),
      .rise_o (rs1)
`ifdef INPUT_COND_FALL_EN
      ,
      .fall_o (fl1)
`endif
   );

   int ncmp = 0;
   int nerr = 0;

   // model: raw sampled per edge, and the synced value seen per edge
   logic [1:0] hist[$];
   logic [1:0] cq[$];
   logic [1:0] m_lv4, m_rs4, m_fl4, m_lv1, m_rs1, m_fl1;

   int ed;
   int first4, first1, nrise4;

   task automatic chk(input string tag, input logic [1:0] obs,
                      input logic [1:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s edge=%0d observed=%b expected=%b",
                tag, ed, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      ncmp++;
      assert (obs == exp) else begin
         nerr++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic win(input int d, input int ch, input logic l);
      if (cq.size() < d) return 1'b0;
      for (int i = cq.size() - d; i < cq.size(); i++)
         if (cq[i][ch] == l) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      hist.delete();
      cq.delete();
      for (int i = 0; i < S; i++) hist.push_back(2'b00);
      m_lv4 = '0; m_rs4 = '0; m_fl4 = '0;
      m_lv1 = '0; m_rs1 = '0; m_fl1 = '0;
      ed = 0;
   endtask

   task automatic model_edge(input logic [1:0] r);
      logic [1:0] c;
      hist.push_back(r);
      c = hist[hist.size() - 1 - S];
      cq.push_back(c);
      if (hist.size() > 16) void'(hist.pop_front());
      if (cq.size() > 16) void'(cq.pop_front());
      m_rs4 = '0; m_fl4 = '0; m_rs1 = '0; m_fl1 = '0;
      for (int ch = 0; ch < 2; ch++) begin
         if (win(4, ch, m_lv4[ch])) begin
            m_lv4[ch] = c[ch];
            m_rs4[ch] = c[ch];
            m_fl4[ch] = ~c[ch];
         end
         if (win(1, ch, m_lv1[ch])) begin
            m_lv1[ch] = c[ch];
            m_rs1[ch] = c[ch];
            m_fl1[ch] = ~c[ch];
         end
      end
   endtask

   // one clock: drive at negedge, edge, check at next negedge
   task automatic cyc(input logic [1:0] r);
      raw = r;
      @(posedge clk);
      ed++;
      model_edge(r);
      @(negedge clk);
      chk("level_d4", lv4, m_lv4);
      chk("rise_d4", rs4, m_rs4);
      chk("level_d1", lv1, m_lv1);
      chk("rise_d1", rs1, m_rs1);
`ifdef INPUT_COND_FALL_EN
      chk("fall_d4", fl4, m_fl4);
      chk("fall_d1", fl1, m_fl1);
      chk("rise_fall_excl", rs4 & fl4, 2'b00);
`endif
      if (rs4[0]) nrise4++;
      if (rs4[0] && first4 < 0) first4 = ed;
      if (rs1[0] && first1 < 0) first1 = ed;
   endtask

   task automatic mark();
      ed = 0; first4 = -1; first1 = -1; nrise4 = 0;
   endtask

   task automatic hold(input logic [1:0] r, input int n);
      for (int i = 0; i < n; i++) cyc(r);
   endtask

   task automatic do_reset(input logic [1:0] r);
      raw = r;
      rst = 1'b1;
      #1;
      chk("reset_level", lv4, 2'b00);
      chk("reset_rise", rs4, 2'b00);
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [1:0] r;
      int         n;
      model_reset();
      mark();
      repeat (3) @(negedge clk);
      chk("reset_level_d4", lv4, 2'b00);
      chk("reset_rise_d4", rs4, 2'b00);
      chk("reset_level_d1", lv1, 2'b00);
      rst = 1'b0;

      // clean press on ch0
      mark();
      hold(2'b01, 9);
      chk_int("press_edge_d4", first4, 6);
      chk_int("press_edge_d1", first1, 3);
      chk_int("press_pulses", nrise4, 1);
      hold(2'b00, 8);

      // bounce then steady high
      mark();
      cyc(2'b01); cyc(2'b00); cyc(2'b01);
      cyc(2'b01); cyc(2'b00); cyc(2'b01);
      hold(2'b01, 10);
      chk_int("bounce_pulses", nrise4, 1);
      chk("bounce_level", lv4, 2'b01);
      hold(2'b00, 8);

      // 3-cycle glitch
      mark();
      hold(2'b01, 3);
      hold(2'b00, 10);
      chk_int("glitch_pulses", nrise4, 0);
      chk("glitch_level", lv4, 2'b00);

      // both up, then both down together
      hold(2'b11, 8);
      mark();
      hold(2'b00, 5);
      chk("release_pre", lv4, 2'b11);
      hold(2'b00, 1);
      chk("release_edge6", lv4, 2'b00);
      chk_int("release_pulses", nrise4, 0);

      // reset with levels high, then reset mid-count
      hold(2'b11, 8);
      do_reset(2'b11);
      hold(2'b00, 8);
      mark();
      hold(2'b01, 4);
      do_reset(2'b01);
      mark();
      hold(2'b01, 9);
      chk_int("rst_release_edge", first4, 6);
      chk_int("rst_release_pulses", nrise4, 1);

      // random traffic with random hold lengths
      for (int k = 0; k < 120; k++) begin
         r = 2'($urandom_range(0, 3));
         n = $urandom_range(1, 7);
         if ($urandom_range(0, 39) == 0) begin
            do_reset(r);
         end
         hold(r, n);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
